// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer dual-port RAM controller.
package fb_pkg;

   // Clear-engine sequencing
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } fb_state_e;

   // Number of byte lanes in a data word
   function automatic int fb_be_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/fb_tdp_ram.sv
// Inferrable dual-port RAM: one byte-enabled write port and two registered
// read ports. A read of the address being written returns the old word.
module fb_tdp_ram
  import fb_pkg::*;
#(
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 19200,
  parameter int    ADDR_W    = 15,
  parameter string INIT_FILE = "",
  localparam int   BE_W      = fb_be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read port A register; holds its value when not enabled
  always_ff @(posedge clk) begin
    if (re_a) rdata_a <= mem[raddr_a];
  end

  // Read port B register; holds its value when not enabled
  always_ff @(posedge clk) begin
    if (re_b) rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/fb_dpram_ctrl.sv
// Framebuffer controller: Avalon-MM port A, read-only video port B and a
// hardware clear engine sharing a single RAM write port.
module fb_dpram_ctrl
   import fb_pkg::*;
#(
   parameter int    DATA_W    = 8,
   parameter int    DEPTH     = 19200,
   parameter int    ADDR_W    = 15,
   parameter string INIT_FILE = "fb_dpram_ctrl.hex",
   localparam int   BE_W      = fb_be_width(DATA_W)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_chipselect,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   input  logic [BE_W-1:0]   avs_byteenable,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic              avs_waitrequest,
   input  logic [ADDR_W-1:0] vid_address,
   input  logic              vid_read,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_valid,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_value,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
   endfunction

   fb_state_e         state, state_nx;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] clr_val;
   logic              wait_q, busy_q, done_q;

   logic              a_acc, a_wr, a_rd, a_in_rng, b_in_rng;
   logic              ram_we, ram_re_a, ram_re_b;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [BE_W-1:0]   ram_wbe;
   logic [DATA_W-1:0] ram_rdata_a, ram_rdata_b;

   logic              rvld_p1, a_zero_p1;
   logic              vvld_p1, b_zero_p1;

   // Port A handshake; read+write together is treated as a write only
   assign a_acc    = avs_chipselect & (avs_read | avs_write) & ~wait_q;
   assign a_wr     = a_acc & avs_write;
   assign a_rd     = a_acc & avs_read & ~avs_write;
   assign a_in_rng = in_range(avs_address);
   assign b_in_rng = in_range(vid_address);

   // Out-of-range reads skip the RAM and are forced to zero at the output
   assign ram_re_a = a_rd & a_in_rng;
   assign ram_re_b = vid_read & b_in_rng;

   // Write-port mux: the clear engine owns the port while clearing,
   // port A is stalled then so the two never compete
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = avs_address;
      ram_wdata = avs_writedata;
      ram_wbe   = avs_byteenable;
      if (state == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_cnt;
         ram_wdata = clr_val;
         ram_wbe   = '1;
      end else if (a_wr && a_in_rng) begin
         ram_we    = 1'b1;
      end
   end

   // Clear-engine next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (clr_start) state_nx = CLEAR;
         CLEAR:   if (clr_cnt == LAST_ADDR) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State and registered status flags, all derived from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         wait_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         wait_q <= (state_nx == CLEAR);
         busy_q <= (state_nx == CLEAR);
         done_q <= (state_nx == DONE);
      end
   end

   // Clear address counter; stops at the last word so it never wraps
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_cnt <= '0;
      end else if (state == IDLE && clr_start) begin
         clr_cnt <= '0;
      end else if (state == CLEAR && clr_cnt != LAST_ADDR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // Fill value captured when a clear is launched
   always_ff @(posedge clk) begin
      if (state == IDLE && clr_start) clr_val <= clr_value;
   end

   fb_tdp_ram #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .INIT_FILE(INIT_FILE)
   ) u_ram (
      .clk    (clk),
      .we     (ram_we),
      .waddr  (ram_waddr),
      .wdata  (ram_wdata),
      .wbe    (ram_wbe),
      .re_a   (ram_re_a),
      .raddr_a(avs_address),
      .rdata_a(ram_rdata_a),
      .re_b   (ram_re_b),
      .raddr_b(vid_address),
      .rdata_b(ram_rdata_b)
   );

   // Port A valid pipeline; the zero flag masks out-of-range and post-reset data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvld_p1   <= 1'b0;
         a_zero_p1 <= 1'b1;
      end else begin
         rvld_p1 <= a_rd;
         if (a_rd) a_zero_p1 <= ~a_in_rng;
      end
   end

   // Port B valid pipeline; never stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vvld_p1   <= 1'b0;
         b_zero_p1 <= 1'b1;
      end else begin
         vvld_p1 <= vid_read;
         if (vid_read) b_zero_p1 <= ~b_in_rng;
      end
   end

   assign avs_readdata      = a_zero_p1 ? '0 : ram_rdata_a;
   assign avs_readdatavalid = rvld_p1;
   assign avs_waitrequest   = wait_q;
   assign vid_data          = b_zero_p1 ? '0 : ram_rdata_b;
   assign vid_valid         = vvld_p1;
   assign clr_busy          = busy_q;
   assign clr_done          = done_q;

endmodule

// File: tb/tb_fb_dpram_ctrl.sv
// Self-checking bench for fb_dpram_ctrl (32-bit words, default depth).
module tb_fb_dpram_ctrl;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 19200;
   localparam int ADDR_W = 15;
   localparam int BE_W   = 4;
   localparam int BUDGET = 30000;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W-1:0] avs_address = '0;
   logic              avs_chipselect = 1'b0;
   logic              avs_read = 1'b0;
   logic              avs_write = 1'b0;
   logic [DATA_W-1:0] avs_writedata = '0;
   logic [BE_W-1:0]   avs_byteenable = '0;
   logic [DATA_W-1:0] avs_readdata;
   logic              avs_readdatavalid;
   logic              avs_waitrequest;
   logic [ADDR_W-1:0] vid_address = '0;
   logic              vid_read = 1'b0;
   logic [DATA_W-1:0] vid_data;
   logic              vid_valid;
   logic              clr_start = 1'b0;
   logic [DATA_W-1:0] clr_value = '0;
   logic              clr_busy;
   logic              clr_done;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   fb_dpram_ctrl #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .INIT_FILE("")
   ) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .avs_address      (avs_address),
      .avs_chipselect   (avs_chipselect),
      .avs_read         (avs_read),
      .avs_write        (avs_write),
      .avs_writedata    (avs_writedata),
      .avs_byteenable   (avs_byteenable),
      .avs_readdata     (avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .avs_waitrequest  (avs_waitrequest),
      .vid_address      (vid_address),
      .vid_read         (vid_read),
      .vid_data         (vid_data),
      .vid_valid        (vid_valid),
      .clr_start        (clr_start),
      .clr_value        (clr_value),
      .clr_busy         (clr_busy),
      .clr_done         (clr_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A clear launched at edge S owns edges S+1..S+DEPTH (word k written at
   // edge S+1+k), is busy after edges S..S+DEPTH-1 and done after edge S+DEPTH.
   logic [31:0] m_mem [DEPTH];
   bit          m_kn  [DEPTH];
   longint      e = 0;
   bit          s_vld = 0;
   longint      s_edge = 0;
   logic [31:0] clr_v = '0;
   logic [31:0] x_rdata = '0, x_vdata = '0;
   bit          x_rkn = 1, x_vkn = 1;
   bit          x_rvld = 0, x_vvld = 0, x_busy = 0, x_done = 0;

   function automatic bit in_clear(input longint ed);
      return s_vld && ed >= s_edge && ed <= s_edge + DEPTH - 1;
   endfunction

   function automatic bit in_done(input longint ed);
      return s_vld && ed == s_edge + DEPTH;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e = 0; s_vld = 0;
         x_rdata = '0; x_vdata = '0; x_rkn = 1; x_vkn = 1;
         x_rvld = 0; x_vvld = 0; x_busy = 0; x_done = 0;
      end else begin
         longint pe;
         bit     acc, idle_before;
         int     a;
         e++;
         pe = e - 1;
         idle_before = !(in_clear(pe) || in_done(pe));
         // port B sees memory before this edge's write
         x_vvld = vid_read;
         if (vid_read) begin
            a = int'(vid_address);
            if (a < DEPTH) begin x_vdata = m_mem[a]; x_vkn = m_kn[a]; end
            else begin x_vdata = '0; x_vkn = 1; end
         end
         acc = avs_chipselect && (avs_read || avs_write) && !in_clear(pe);
         x_rvld = acc && avs_read && !avs_write;
         if (x_rvld) begin
            a = int'(avs_address);
            if (a < DEPTH) begin x_rdata = m_mem[a]; x_rkn = m_kn[a]; end
            else begin x_rdata = '0; x_rkn = 1; end
         end
         if (in_clear(pe)) begin
            a = int'(pe - s_edge);
            m_mem[a] = clr_v; m_kn[a] = 1;
         end
         if (acc && avs_write && int'(avs_address) < DEPTH) begin
            a = int'(avs_address);
            for (int i = 0; i < BE_W; i++)
               if (avs_byteenable[i]) m_mem[a][i*8 +: 8] = avs_writedata[i*8 +: 8];
            if (avs_byteenable == 4'hF) m_kn[a] = 1;
         end
         if (clr_start && idle_before) begin
            s_vld = 1; s_edge = e; clr_v = clr_value;
         end
         x_busy = in_clear(e);
         x_done = in_done(e);
      end
   end

   // Cycle-by-cycle comparison against the model, plus pulse counters
   always @(negedge clk) begin
      chk("readdatavalid", 32'(avs_readdatavalid), 32'(x_rvld));
      if (x_rkn) chk("readdata", avs_readdata, x_rdata);
      chk("waitrequest", 32'(avs_waitrequest), 32'(x_busy));
      chk("vid_valid", 32'(vid_valid), 32'(x_vvld));
      if (x_vkn) chk("vid_data", vid_data, x_vdata);
      chk("clr_busy", 32'(clr_busy), 32'(x_busy));
      chk("clr_done", 32'(clr_done), 32'(x_done));
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic a_write(input int a, input logic [31:0] d, input logic [3:0] be);
      int n = 0;
      avs_chipselect = 1; avs_write = 1; avs_read = 0;
      avs_address = ADDR_W'(a); avs_writedata = d; avs_byteenable = be;
      while (avs_waitrequest && n < BUDGET) begin tick(); n++; end
      chk("write_wait_release", 32'(avs_waitrequest), 0);
      tick();
      avs_chipselect = 0; avs_write = 0;
   endtask

   task automatic a_read(input int a, output logic [31:0] d);
      int n = 0;
      avs_chipselect = 1; avs_read = 1; avs_write = 0; avs_address = ADDR_W'(a);
      while (avs_waitrequest && n < BUDGET) begin tick(); n++; end
      tick();
      avs_chipselect = 0; avs_read = 0;
      @(negedge clk);
      chk("rdv_one_cycle", 32'(avs_readdatavalid), 1);
      d = avs_readdata;
      @(negedge clk);
      chk("rdv_single_pulse", 32'(avs_readdatavalid), 0);
   endtask

   task automatic v_read(input int a, output logic [31:0] d);
      vid_address = ADDR_W'(a); vid_read = 1;
      tick();
      vid_read = 0;
      @(negedge clk);
      chk("vid_valid_latency", 32'(vid_valid), 1);
      d = vid_data;
   endtask

   task automatic start_clear(input logic [31:0] v);
      clr_start = 1; clr_value = v;
      tick();
      clr_start = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!clr_done && n < BUDGET) begin tick(); n++; end
      chk("clr_done_seen", 32'(clr_done), 1);
      tick();
      chk("clr_done_one_cycle", 32'(clr_done), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] d;
      int n;
      repeat (3) tick();
      reset_n = 1;
      tick();

      // Async reset mid-run clears outputs before any edge
      a_write(5, 32'h11223344, 4'hF);
      a_read(5, d);            chk("rd_full_word", d, 32'h11223344);
      v_read(5, d);            chk("vid_full_word", d, 32'h11223344);
      tick();
      reset_n = 0;
      #1;
      chk("rst_readdata", avs_readdata, 0);
      chk("rst_vid_data", vid_data, 0);
      chk("rst_outputs", {27'd0, avs_readdatavalid, avs_waitrequest, vid_valid, clr_busy, clr_done}, 0);
      repeat (2) tick();
      reset_n = 1;
      tick();

      // Byte enables
      a_write(5, 32'hAABBCCDD, 4'b0101);
      a_read(5, d);            chk("be_0101", d, 32'h11BB33DD);
      a_write(6, 32'h11223344, 4'hF);
      a_write(6, 32'hAABBCCDD, 4'b0100);
      a_read(6, d);            chk("be_0100", d, 32'h11BB3344);

      // Read and write together: write only, no readdatavalid
      avs_chipselect = 1; avs_read = 1; avs_write = 1;
      avs_address = 8; avs_writedata = 32'h99; avs_byteenable = 4'hF;
      tick();
      avs_chipselect = 0; avs_read = 0; avs_write = 0;
      a_read(8, d);            chk("rw_together", d, 32'h99);

      // Back-to-back reads
      avs_chipselect = 1; avs_read = 1; avs_address = 5;
      tick();
      avs_address = 6;
      tick();
      avs_chipselect = 0; avs_read = 0;
      @(negedge clk);          chk("b2b_second", avs_readdata, 32'h11BB3344);

      // Out of range
      a_write(DEPTH, 32'h55, 4'hF);
      a_read(DEPTH, d);        chk("oor_read_a", d, 0);
      v_read(DEPTH, d);        chk("oor_read_b", d, 0);

      // Collision: port B gets old data
      a_write(7, 32'h10, 4'hF);
      avs_chipselect = 1; avs_write = 1; avs_address = 7;
      avs_writedata = 32'h20; avs_byteenable = 4'hF;
      vid_address = 7; vid_read = 1;
      tick();
      avs_chipselect = 0; avs_write = 0; vid_read = 0;
      @(negedge clk);          chk("collision_old", vid_data, 32'h10);
      v_read(7, d);            chk("collision_new", d, 32'h20);

      // Full clear with a stalled port A write and scan-out during the clear
      busy_cnt = 0; done_cnt = 0;
      start_clear(32'h3C);
      fork
         begin
            avs_chipselect = 1; avs_write = 1; avs_address = 100;
            avs_writedata = 32'h7E; avs_byteenable = 4'hF;
            n = 0;
            while (avs_waitrequest && n < BUDGET) begin tick(); n++; end
            chk("stall_cycles", 32'(n), 32'(DEPTH));
            chk("stall_release_in_done", 32'(clr_done), 1);
            tick();
            avs_chipselect = 0; avs_write = 0;
         end
         begin
            logic [31:0] dv;
            repeat (50) tick();
            v_read(0, dv);     chk("scan_during_clear", dv, 32'h3C);
         end
      join
      chk("busy_cycles", 32'(busy_cnt), 32'(DEPTH));
      chk("done_pulses", 32'(done_cnt), 1);
      a_read(100, d);          chk("stalled_write", d, 32'h7E);
      v_read(0, d);            chk("clr_addr0", d, 32'h3C);
      v_read(9600, d);         chk("clr_addr9600", d, 32'h3C);
      v_read(DEPTH - 1, d);    chk("clr_addr_last", d, 32'h3C);
      a_read(0, d);            chk("no_alias_write", d, 32'h3C);

      // Reset in the middle of a clear
      a_write(19000, 32'h12345678, 4'hF);
      done_cnt = 0;
      start_clear(32'hA5);
      repeat (500) tick();
      reset_n = 0;
      #1;
      chk("midclr_busy", 32'(clr_busy), 0);
      chk("midclr_wait", 32'(avs_waitrequest), 0);
      repeat (3) tick();
      reset_n = 1;
      tick();
      chk("midclr_no_done", 32'(done_cnt), 0);
      v_read(0, d);            chk("partial_addr0", d, 32'hA5);
      v_read(19000, d);        chk("partial_addr19000", d, 32'h12345678);
      v_read(1000, d);         chk("partial_addr1000", d, 32'h3C);

      // A new clear completes normally
      busy_cnt = 0; done_cnt = 0;
      start_clear(32'h5A);
      wait_done();
      chk("reclear_busy", 32'(busy_cnt), 32'(DEPTH));
      chk("reclear_done", 32'(done_cnt), 1);
      v_read(19000, d);        chk("reclear_19000", d, 32'h5A);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
